// File: rtl/fdtd_pingpong_buffer_pkg.sv
// Shared types and helpers for the multi-channel FDTD ping-pong field buffer.
package fdtd_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DRAIN_RD  = 3'd2,
        ST_DRAIN_OUT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    // A single channel still needs a 1-bit select field.
    function automatic int calc_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fdtd_pingpong_buffer_if.sv
// DMA load/drain streams, engine rd/wr ports and swap/status bundle of the ping-pong buffer.
interface fdtd_pingpong_buffer_if
    import fdtd_buf_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int NUM_CH            = 3
);
    localparam int DW   = FDTD_DATA_WIDTH;
    localparam int AW   = BUFFER_ADDR_WIDTH;
    localparam int CH_W = calc_ch_w(NUM_CH);

    logic [AW:0]           buffer_size_i;
    logic                  load_start_i;
    logic [CH_W-1:0]       load_ch_i;
    logic                  load_valid_i;
    logic [DW-1:0]         load_data_i;
    logic                  load_done_o;
    logic [NUM_CH-1:0]     rd_en_i;
    logic [NUM_CH*AW-1:0]  rd_addr_i;
    logic [NUM_CH*DW-1:0]  rd_data_o;
    logic [NUM_CH-1:0]     wr_en_i;
    logic [NUM_CH*AW-1:0]  wr_addr_i;
    logic [NUM_CH*DW-1:0]  wr_data_i;
    logic                  drain_start_i;
    logic [CH_W-1:0]       drain_ch_i;
    logic                  drain_valid_o;
    logic                  drain_ready_i;
    logic [DW-1:0]         drain_data_o;
    logic                  drain_last_o;
    logic                  drain_done_o;
    logic [NUM_CH-1:0]     swap_i;
    logic [NUM_CH-1:0]     bank_sel_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        output buffer_size_i, load_start_i, load_ch_i, load_valid_i, load_data_i,
               rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               drain_start_i, drain_ch_i, drain_ready_i, swap_i,
        input  load_done_o, rd_data_o, drain_valid_o, drain_data_o, drain_last_o,
               drain_done_o, bank_sel_o, busy_o, err_o
    );

    modport slave (
        input  buffer_size_i, load_start_i, load_ch_i, load_valid_i, load_data_i,
               rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               drain_start_i, drain_ch_i, drain_ready_i, swap_i,
        output load_done_o, rd_data_o, drain_valid_o, drain_data_o, drain_last_o,
               drain_done_o, bank_sel_o, busy_o, err_o
    );

endinterface

// File: rtl/fdtd_pingpong_buffer_ram.sv
// 1W/1R field bank, registered read (1 cycle); read-during-write to one address returns old data.
module fdtd_ram #(
    parameter int DW    = 32,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_rdata <= '0;
        else if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/fdtd_pingpong_buffer.sv
// Per-channel ping-pong banks: DMA loads old bank, engine reads old (1-cycle) / writes new, drain streams new.
// Load is never stalled; drain is valid/ready at 1 word/cycle via prefetch + skid register.
module fdtd_pingpong_buffer
    import fdtd_buf_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int FDTD_BUFFER_DEPTH = 64,
    parameter int NUM_CH            = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    fdtd_pingpong_buffer_if.slave bus
);
    localparam int DW   = FDTD_DATA_WIDTH;
    localparam int AW   = BUFFER_ADDR_WIDTH;
    localparam int CH_W = calc_ch_w(NUM_CH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(FDTD_BUFFER_DEPTH);
    localparam logic [CH_W:0] NCH_L   = (CH_W+1)'(NUM_CH);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);

    state_t            r_state;
    logic [CH_W-1:0]   r_ch;
    logic [AW:0]       r_size, r_addr, r_out_cnt;
    logic              r_op_load, r_load_done, r_drain_done, r_err;
    logic              r_out_vld, r_skid_vld, r_inflight;
    logic [DW-1:0]     r_out_dat, r_skid_dat;
    logic [NUM_CH-1:0] r_bank_sel, r_swap_pend, r_rd_oor, r_rd_bank;

    logic [DW-1:0]     w_ram_rdata [NUM_CH][2];
    logic [DW-1:0]     w_arrival;
    logic [NUM_CH-1:0] w_ch_hit, w_defer, w_wr_oor, w_rd_oor;
    logic [CH_W-1:0]   w_start_ch;
    logic              w_start, w_start_bad, w_eng_err;
    logic              w_drain_pop, w_drain_issue, w_last_word;
    logic [1:0]        w_occ;

    assign w_start     = bus.load_start_i | bus.drain_start_i;
    assign w_start_ch  = bus.load_start_i ? bus.load_ch_i : bus.drain_ch_i;
    assign w_start_bad = (r_state == ST_IDLE) && w_start &&
                         ((bus.buffer_size_i > DEPTH_L) || ({1'b0, w_start_ch} >= NCH_L));

    // Words held in out/skid plus the one in flight from the RAM bound the prefetch.
    assign w_drain_pop   = r_out_vld & bus.drain_ready_i;
    assign w_last_word   = (r_out_cnt + ONE) == r_size;
    assign w_occ         = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_inflight} - {1'b0, w_drain_pop};
    assign w_drain_issue = (r_state == ST_DRAIN_RD) && (w_occ < 2'd2);
    assign w_defer       = w_ch_hit & {NUM_CH{r_state != ST_IDLE}};
    assign w_eng_err     = |((bus.wr_en_i & w_wr_oor) | (bus.rd_en_i & w_rd_oor));

    always_comb begin
        w_ch_hit  = '0;
        w_wr_oor  = '0;
        w_rd_oor  = '0;
        w_arrival = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_hit[c] = (r_ch == CH_W'(c));
            w_wr_oor[c] = {1'b0, bus.wr_addr_i[c*AW +: AW]} >= DEPTH_L;
            w_rd_oor[c] = {1'b0, bus.rd_addr_i[c*AW +: AW]} >= DEPTH_L;
            if (w_ch_hit[c])
                w_arrival = r_bank_sel[c] ? w_ram_rdata[c][0] : w_ram_rdata[c][1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_ch         <= '0;
            r_size       <= '0;
            r_addr       <= '0;
            r_op_load    <= 1'b0;
            r_load_done  <= 1'b0;
            r_drain_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load_done  <= 1'b0;
            r_drain_done <= 1'b0;
            if (w_start_bad || w_eng_err)
                r_err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_start_bad) begin
                        r_ch      <= w_start_ch;
                        r_size    <= bus.buffer_size_i;
                        r_addr    <= '0;
                        r_op_load <= bus.load_start_i;
                        if (bus.buffer_size_i == '0)
                            r_state <= ST_DONE;
                        else if (bus.load_start_i)
                            r_state <= ST_LOAD;
                        else
                            r_state <= ST_DRAIN_RD;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_valid_i) begin
                        r_addr <= r_addr + ONE;
                        if ((r_addr + ONE) == r_size)
                            r_state <= ST_DONE;
                    end
                end
                ST_DRAIN_RD: begin
                    if (w_drain_issue) begin
                        r_addr <= r_addr + ONE;
                        if ((r_addr + ONE) == r_size)
                            r_state <= ST_DRAIN_OUT;
                    end
                end
                ST_DRAIN_OUT: begin
                    if (w_drain_pop && w_last_word)
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_load_done  <= r_op_load;
                    r_drain_done <= ~r_op_load;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_inflight <= 1'b0;
            r_out_dat  <= '0;
            r_skid_dat <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_inflight <= w_drain_issue;
            r_out_cnt  <= (r_state == ST_IDLE) ? '0 : (w_drain_pop ? r_out_cnt + ONE : r_out_cnt);
            if (w_drain_pop) begin
                if (r_skid_vld) begin
                    r_out_dat  <= r_skid_dat;
                    r_skid_vld <= r_inflight;
                    if (r_inflight)
                        r_skid_dat <= w_arrival;
                end else begin
                    r_out_vld <= r_inflight;
                    if (r_inflight)
                        r_out_dat <= w_arrival;
                end
            end else if (r_inflight) begin
                if (!r_out_vld) begin
                    r_out_vld <= 1'b1;
                    r_out_dat <= w_arrival;
                end else begin
                    r_skid_vld <= 1'b1;
                    r_skid_dat <= w_arrival;
                end
            end
        end
    end

    // A swap on the channel owned by the FSM accumulates until the first IDLE cycle after DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bank_sel  <= '0;
            r_swap_pend <= '0;
            r_rd_oor    <= '0;
            r_rd_bank   <= '0;
        end else begin
            r_swap_pend <= w_defer & (r_swap_pend ^ bus.swap_i);
            r_bank_sel  <= r_bank_sel ^ (~w_defer & (r_swap_pend ^ bus.swap_i));
            r_rd_oor    <= (bus.rd_en_i & w_rd_oor) | (~bus.rd_en_i & r_rd_oor);
            r_rd_bank   <= (bus.rd_en_i & r_bank_sel) | (~bus.rd_en_i & r_rd_bank);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic          w_is_old, w_we, w_re;
            logic [AW-1:0] w_waddr, w_raddr;
            logic [DW-1:0] w_wdata;

            assign w_is_old = (r_bank_sel[c] == ((b == 0) ? BANK0 : BANK1));
            assign w_we     = w_is_old ? ((r_state == ST_LOAD) && bus.load_valid_i && w_ch_hit[c])
                                       : (bus.wr_en_i[c] && !w_wr_oor[c]);
            assign w_waddr  = w_is_old ? r_addr[AW-1:0] : bus.wr_addr_i[c*AW +: AW];
            assign w_wdata  = w_is_old ? bus.load_data_i : bus.wr_data_i[c*DW +: DW];
            assign w_re     = w_is_old ? bus.rd_en_i[c] : (w_drain_issue && w_ch_hit[c]);
            assign w_raddr  = w_is_old ? bus.rd_addr_i[c*AW +: AW] : r_addr[AW-1:0];

            fdtd_ram #(
                .DW    (DW),
                .AW    (AW),
                .DEPTH (FDTD_BUFFER_DEPTH)
            ) u_ram (
                .i_clk   (CLK),
                .i_rst_n (RST_N),
                .i_we    (w_we),
                .i_waddr (w_waddr),
                .i_wdata (w_wdata),
                .i_re    (w_re),
                .i_raddr (w_raddr),
                .o_rdata (w_ram_rdata[c][b])
            );
        end

        assign bus.rd_data_o[c*DW +: DW] = r_rd_oor[c] ? '0
                                         : (r_rd_bank[c] ? w_ram_rdata[c][1] : w_ram_rdata[c][0]);
    end

    assign bus.load_done_o   = r_load_done;
    assign bus.drain_done_o  = r_drain_done;
    assign bus.drain_valid_o = r_out_vld;
    assign bus.drain_data_o  = r_out_dat;
    assign bus.drain_last_o  = r_out_vld && w_last_word;
    assign bus.bank_sel_o    = r_bank_sel;
    assign bus.busy_o        = (r_state != ST_IDLE);
    assign bus.err_o         = r_err;

endmodule

// File: tb/tb_fdtd_pingpong_buffer.sv
// Directed bench for fdtd_pingpong_buffer: load/read, drain with stalls, swaps, size/channel errors, reset.
module tb_fdtd_pingpong_buffer;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NC = 3;

    logic CLK;
    logic RST_N;

    int n_chk;
    int n_fail;
    logic [NC-1:0] exp_sel;

    fdtd_pingpong_buffer_if #(
        .FDTD_DATA_WIDTH   (DW),
        .BUFFER_ADDR_WIDTH (AW),
        .NUM_CH            (NC)
    ) ifc ();

    fdtd_pingpong_buffer #(
        .FDTD_DATA_WIDTH   (DW),
        .BUFFER_ADDR_WIDTH (AW),
        .FDTD_BUFFER_DEPTH (64),
        .NUM_CH            (NC)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (ifc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic eng_wr(input int ch, input int addr, input logic [DW-1:0] d);
        ifc.wr_en_i[ch]            = 1'b1;
        ifc.wr_addr_i[ch*AW +: AW] = AW'(addr);
        ifc.wr_data_i[ch*DW +: DW] = d;
        cyc();
        ifc.wr_en_i[ch] = 1'b0;
    endtask

    task automatic eng_rd_chk(input string tag, input int ch, input int addr, input logic [DW-1:0] exp);
        ifc.rd_en_i[ch]            = 1'b1;
        ifc.rd_addr_i[ch*AW +: AW] = AW'(addr);
        cyc();
        ifc.rd_en_i[ch] = 1'b0;
        chk_eq(tag, ifc.rd_data_o[ch*DW +: DW], exp);
    endtask

    task automatic load_run(input int ch, input int size, input logic [DW-1:0] base);
        ifc.load_start_i  = 1'b1;
        ifc.load_ch_i     = 2'(ch);
        ifc.buffer_size_i = 7'(size);
        cyc();
        ifc.load_start_i = 1'b0;
        chk_eq("load_busy", ifc.busy_o, 1);
        for (int i = 0; i < size; i++) begin
            ifc.load_valid_i = 1'b1;
            ifc.load_data_i  = base + DW'(i);
            cyc();
        end
        ifc.load_valid_i = 1'b0;
        chk_eq("load_done_early", ifc.load_done_o, 0);
        cyc();
        chk_eq("load_done_pulse", ifc.load_done_o, 1);
        cyc();
        chk_eq("load_done_clear", ifc.load_done_o, 0);
        chk_eq("load_idle", ifc.busy_o, 0);
    endtask

    task automatic drain_run(input int ch, input int size, input logic [DW-1:0] base,
                             input bit toggle, input logic [NC-1:0] smask);
        int k;
        bit done_seen;
        logic [NC-1:0] mid_sel;
        logic [NC-1:0] fin_sel;
        k         = 0;
        done_seen = 1'b0;
        mid_sel   = exp_sel ^ (smask & ~(3'b001 << ch));
        fin_sel   = exp_sel ^ smask;
        ifc.drain_start_i = 1'b1;
        ifc.drain_ch_i    = 2'(ch);
        ifc.buffer_size_i = 7'(size);
        cyc();
        ifc.drain_start_i = 1'b0;
        for (int n = 0; n < 80 && !done_seen; n++) begin
            ifc.drain_ready_i = toggle ? (n % 2 == 0) : 1'b1;
            ifc.swap_i        = (n == 1) ? smask : '0;
            if (n == 2)
                chk_eq("swap_other_now", ifc.bank_sel_o, mid_sel);
            if (ifc.drain_valid_o) begin
                chk_eq("drain_dat", ifc.drain_data_o, base + DW'(k));
                chk_eq("drain_last", ifc.drain_last_o, (k == size - 1));
                if (ifc.drain_ready_i)
                    k++;
            end
            if (ifc.drain_done_o) begin
                done_seen = 1'b1;
                chk_eq("drain_cnt", k, size);
                chk_eq("swap_deferred", ifc.bank_sel_o, mid_sel);
            end
            cyc();
        end
        ifc.drain_ready_i = 1'b0;
        ifc.swap_i        = '0;
        chk_eq("drain_done_seen", done_seen, 1);
        chk_eq("drain_done_1cyc", ifc.drain_done_o, 0);
        chk_eq("swap_after_done", ifc.bank_sel_o, fin_sel);
        exp_sel = fin_sel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        exp_sel = '0;
        RST_N   = 1'b0;
        ifc.buffer_size_i = '0;
        ifc.load_start_i  = 1'b0;
        ifc.load_ch_i     = '0;
        ifc.load_valid_i  = 1'b0;
        ifc.load_data_i   = '0;
        ifc.rd_en_i       = '0;
        ifc.rd_addr_i     = '0;
        ifc.wr_en_i       = '0;
        ifc.wr_addr_i     = '0;
        ifc.wr_data_i     = '0;
        ifc.drain_start_i = 1'b0;
        ifc.drain_ch_i    = '0;
        ifc.drain_ready_i = 1'b0;
        ifc.swap_i        = '0;
        cyc();
        cyc();
        chk_eq("rst_bank_sel", ifc.bank_sel_o, 0);
        chk_eq("rst_busy", ifc.busy_o, 0);
        chk_eq("rst_err", ifc.err_o, 0);
        chk_eq("rst_drain_vld", ifc.drain_valid_o, 0);
        chk_eq("rst_rd_data", ifc.rd_data_o, 0);
        RST_N = 1'b1;
        cyc();

        // Load ch0 old bank and read it back through the engine port.
        load_run(0, 8, 32'h10);
        for (int i = 0; i < 8; i++)
            eng_rd_chk("rd_ch0_load", 0, i, 32'h10 + DW'(i));

        // Engine fills ch1 new bank, drained with a stalling consumer.
        for (int i = 0; i < 4; i++)
            eng_wr(1, i, 32'hA0 + DW'(i));
        drain_run(1, 4, 32'hA0, 1'b1, 3'b000);

        // Fresh ch0 data becomes readable after a swap with no reload.
        for (int i = 0; i < 8; i++)
            eng_wr(0, i, 32'hB0 + DW'(i));
        ifc.swap_i = 3'b001;
        cyc();
        ifc.swap_i = '0;
        exp_sel    = 3'b001;
        chk_eq("swap_ch0", ifc.bank_sel_o, exp_sel);
        for (int i = 0; i < 8; i++)
            eng_rd_chk("rd_ch0_swap", 0, i, 32'hB0 + DW'(i));

        // Swap on ch2 deferred while draining ch2, ch0 swap immediate.
        eng_wr(2, 0, 32'hC0);
        eng_wr(2, 1, 32'hC1);
        eng_wr(2, 2, 32'hC2);
        drain_run(2, 3, 32'hC0, 1'b0, 3'b101);

        // Zero-size drain: done two cycles after start, never valid.
        ifc.drain_start_i = 1'b1;
        ifc.drain_ch_i    = 2'd1;
        ifc.buffer_size_i = 7'd0;
        cyc();
        ifc.drain_start_i = 1'b0;
        chk_eq("sz0_vld_a", ifc.drain_valid_o, 0);
        chk_eq("sz0_done_a", ifc.drain_done_o, 0);
        cyc();
        chk_eq("sz0_vld_b", ifc.drain_valid_o, 0);
        chk_eq("sz0_done_b", ifc.drain_done_o, 1);
        cyc();
        chk_eq("sz0_done_c", ifc.drain_done_o, 0);

        // Channel out of range.
        ifc.load_start_i  = 1'b1;
        ifc.load_ch_i     = 2'd3;
        ifc.buffer_size_i = 7'd4;
        cyc();
        ifc.load_start_i = 1'b0;
        chk_eq("badch_err", ifc.err_o, 1);
        chk_eq("badch_busy", ifc.busy_o, 0);

        // Reset in the middle of a load.
        ifc.load_start_i  = 1'b1;
        ifc.load_ch_i     = 2'd1;
        ifc.buffer_size_i = 7'd8;
        cyc();
        ifc.load_start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.load_valid_i = 1'b1;
            ifc.load_data_i  = 32'hE0 + DW'(i);
            cyc();
        end
        ifc.load_data_i = 32'hE3;
        #3;
        RST_N = 1'b0;
        #1;
        chk_eq("mrst_busy", ifc.busy_o, 0);
        chk_eq("mrst_err", ifc.err_o, 0);
        chk_eq("mrst_bank_sel", ifc.bank_sel_o, 0);
        chk_eq("mrst_rd_data", ifc.rd_data_o, 0);
        chk_eq("mrst_load_done", ifc.load_done_o, 0);
        ifc.load_valid_i = 1'b0;
        exp_sel = '0;
        cyc();
        RST_N = 1'b1;
        cyc();
        load_run(1, 2, 32'hD0);
        eng_rd_chk("rd_ch1_post_rst", 1, 0, 32'hD0);
        eng_rd_chk("rd_ch1_post_rst", 1, 1, 32'hD1);

        // Oversize request.
        ifc.drain_start_i = 1'b1;
        ifc.drain_ch_i    = 2'd0;
        ifc.buffer_size_i = 7'd65;
        cyc();
        ifc.drain_start_i = 1'b0;
        chk_eq("size65_err", ifc.err_o, 1);
        chk_eq("size65_busy", ifc.busy_o, 0);
        cyc();
        chk_eq("size65_idle", ifc.busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
